// File: rtl/led_pio_blink_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : led_pio_blink_if                                   |
// | Description : Avalon-MM slave bus bundle for the LED PIO          |
// |               (address/select/write strobe/data, read data).      |
// | Revision    : 1.0  initial release                                |
// +------------------------------------------------------------------+
interface led_pio_blink_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface
`default_nettype wire

// File: rtl/led_pio_blink.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : led_pio_blink                                      |
// | Description : Parametrised Avalon-MM output PIO for LED banks     |
// |               with DATA/SET/CLEAR registers and per-bit blink     |
// |               driven by a programmable half-period prescaler.     |
// | Revision    : 1.0  initial release                                |
// +------------------------------------------------------------------+
module led_pio_blink #(
   parameter int unsigned          WIDTH       = 9,
   parameter int unsigned          DIV_WIDTH   = 24,
   parameter logic [WIDTH-1:0]     RESET_VALUE = '0,
   parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = 24'd12_499_999
) (
   input  logic              clk,
   input  logic              reset,
   led_pio_blink_if.slave    bus,
   output logic [WIDTH-1:0]  out_port
);

   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_SET    = 3'd1;
   localparam logic [2:0] ADDR_CLEAR  = 3'd2;
   localparam logic [2:0] ADDR_MASK   = 3'd3;
   localparam logic [2:0] ADDR_DIV    = 3'd4;
   localparam logic [2:0] ADDR_STATUS = 3'd5;

   localparam logic [DIV_WIDTH-1:0] DIV_ONE = 1;

   logic                 we;
   logic [WIDTH-1:0]     wd_data;
   logic [DIV_WIDTH-1:0] wd_div;
   logic                 unused_wd;

   logic [WIDTH-1:0]     data;
   logic [WIDTH-1:0]     blink_mask;
   logic [DIV_WIDTH-1:0] blink_div;
   logic [DIV_WIDTH-1:0] cnt;
   logic                 phase;
   logic [31:0]          rd;

   assign we        = bus.chipselect & ~bus.write_n;
   assign wd_data   = bus.writedata[WIDTH-1:0];
   assign wd_div    = bus.writedata[DIV_WIDTH-1:0];
   // Upper write-data bits beyond WIDTH/DIV_WIDTH are deliberately ignored.
   assign unused_wd = ^bus.writedata;

   // Register file: DATA (with atomic set/clear), blink mask and divider.
   always_ff @(posedge clk) begin
      if (reset) begin
         data       <= RESET_VALUE;
         blink_mask <= '0;
         blink_div  <= DEFAULT_DIV;
      end else if (we) begin
         case (bus.address)
            ADDR_DATA:  data       <= wd_data;
            ADDR_SET:   data       <= data | wd_data;
            ADDR_CLEAR: data       <= data & ~wd_data;
            ADDR_MASK:  blink_mask <= wd_data;
            ADDR_DIV:   blink_div  <= wd_div;
            default:    ;
         endcase
      end
   end

   // Prescaler: a divider write restarts the count without touching phase,
   // so lowering the divider below the current count can never overrun.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         phase <= 1'b1;
      end else if (we && bus.address == ADDR_DIV) begin
         cnt   <= '0;
      end else if (cnt == blink_div) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt   <= cnt + DIV_ONE;
      end
   end

   // Output register: blinking bits are gated by phase, dark when DATA is 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_port <= RESET_VALUE;
      end else begin
         out_port <= data & (~blink_mask | {WIDTH{phase}});
      end
   end

   // Combinational, zero-extended read mux; independent of chipselect.
   always_comb begin
      rd = '0;
      case (bus.address)
         ADDR_DATA:   rd[WIDTH-1:0]     = data;
         ADDR_MASK:   rd[WIDTH-1:0]     = blink_mask;
         ADDR_DIV:    rd[DIV_WIDTH-1:0] = blink_div;
         ADDR_STATUS: rd[0]             = phase;
         default:     rd                = '0;
      endcase
   end

   assign bus.readdata = rd;

endmodule
`default_nettype wire

// File: doc/led_pio_blink.md
# led_pio_blink

Parametrised Avalon-MM output PIO for board LED banks, successor to the fixed 9-bit green-LED port. Adds a configurable width, atomic write-1-to-set and write-1-to-clear registers, and a per-bit hardware blink mode driven by an internal programmable prescaler. Sits on the system interconnect as a zero-wait-state slave; `out_port` drives the LED pins directly.

## Interface
- `WIDTH`, 9: number of output bits, 1..32.
- `DIV_WIDTH`, 24: width of the blink half-period divider register, 1..32.
- `RESET_VALUE`, 0: value of DATA, and therefore `out_port`, after reset.
- `DEFAULT_DIV`, 24'd12_499_999: BLINK_DIV value after reset.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `address`  in  3  register word index.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe, qualified by `chipselect`.
- `writedata`  in  32  write data.
- `readdata`  out  32  combinational read data, zero-extended.
- `out_port`  out  WIDTH  registered LED drive.

## Operation
- Write strobe `we = chipselect & ~write_n`. Only `writedata[WIDTH-1:0]` or `[DIV_WIDTH-1:0]` is used; upper bits are ignored.
- Register map:
  - 0 DATA: read/write.
  - 1 SET: write only; `DATA |= wd`; reads 0.
  - 2 CLEAR: write only; `DATA &= ~wd`; reads 0.
  - 3 BLINK_MASK: read/write; bit i = 1 puts bit i in blink mode.
  - 4 BLINK_DIV: read/write; blink half-period is BLINK_DIV+1 clocks.
  - 5 STATUS: read only; bit0 = `phase`, other bits 0.
  - 6 and 7: read 0; writes ignored.
- Prescaler: `cnt` is DIV_WIDTH bits wide.
  - If `cnt == BLINK_DIV`: `cnt <= 0` and `phase <= ~phase`.
  - Otherwise `cnt <= cnt + 1`.
  - BLINK_DIV = 0 toggles `phase` every clock.
- A write to BLINK_DIV sets `cnt <= 0` in the same edge and leaves `phase` unchanged. Comparison then uses the new value.
- Output function, registered: `out_port[i] <= BLINK_MASK[i] ? (DATA[i] & phase) : DATA[i]`. A blinking bit whose DATA bit is 0 stays dark.
- `readdata = {zeros, mux(address)}`, valid in the same cycle as `address`. It does not depend on `chipselect`; the interconnect ignores it otherwise.
- Reads have no side effects.

## Timing
- Reset (`reset` high at an edge) sets:
  - DATA = RESET_VALUE, BLINK_MASK = 0, BLINK_DIV = DEFAULT_DIV.
  - `cnt` = 0, `phase` = 1.
  - `out_port` = RESET_VALUE (loaded directly, not via the pipeline).
- Reset asserted mid-operation overrides any write in that cycle. All state takes its reset values at that edge.
- Register-write latency:
  - A write at edge N updates the register at edge N.
  - `out_port` reflects it at edge N+1. This two-stage path (register, then output register) is fixed at one cycle after the register update.
- Phase latency: a `phase` toggle at edge N appears on `out_port` at edge N+1.
- Only one register is written per cycle, so there are no set/clear collisions. SET or CLEAR with `wd = 0` leaves DATA unchanged.
- `cnt` wraps only through the compare. If BLINK_DIV is lowered below the current `cnt`, the write also clears `cnt`, so no 2^DIV_WIDTH overrun is possible.

## Test plan
- **Reset:** set RESET_VALUE = 9'h155 and hold `reset` for 2 clocks.
  - `out_port` = 0x155 after reset.
  - Reads: addr0 = 0x155, addr3 = 0, addr4 = DEFAULT_DIV, addr5 = 1.
- **Set/clear:** write DATA = 0x0F0, then SET 0x003, then CLEAR 0x030.
  - DATA reads 0x0F0, then 0x0F3, then 0x0C3.
  - `out_port` follows each value one clock after its write.
  - Reads of addr1 and addr2 return 0.
- **Blink:** write DATA = 0x1FF, BLINK_DIV = 3, BLINK_MASK = 0x100.
  - `out_port[8]` toggles every 4 clocks with a 50% duty cycle.
  - `out_port[7:0]` stays at 0xFF.
  - STATUS bit0 matches the phase, one clock ahead of `out_port[8]`.
- **Div edge cases:**
  - BLINK_DIV = 0: `phase` toggles every clock.
  - Write BLINK_DIV = 2 while `cnt` = 10: the next toggle occurs exactly 3 clocks after the write edge.
- **Reset during blink and write:** assert `reset` in the same cycle as a DATA write of 0x0AA.
  - DATA = RESET_VALUE, not 0x0AA.
  - BLINK_MASK = 0 and `phase` = 1.
- **Width/out-of-map:** build with WIDTH = 4 and write 0xFFFF_FFFF to DATA.
  - DATA reads 0x0000000F.
  - Writes to addresses 6 and 7 change no state.
  - Reads of addresses 6 and 7 return 0.
